fib_index: RTL and testbench
============================

Name: fib_index

Overview:
- Inverse of the team's Fibonacci FSMD (`fib`): given a 20-bit value v, finds the largest index n such that F(n) <= v.
- Outputs n, F(n), and an exact flag (F(n) == v).
- Uses the same start/ready/done_tick handshake and the same F definition as `fib`: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- Lets the datapath round-trip values and gives the verification team a checker for `fib`.

Parameters:
- W, 20, width of the input value and of the F(n) output.
- NW, 5, width of the index output. It must hold the largest n with F(n) < 2^W, which is 30 for W=20.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only while ready=1.
- v  in  W  value to invert. Captured on the accepted start.
- ready  out  1  high in idle (combinational from state).
- done_tick  out  1  one-cycle pulse when the result is valid.
- idx  out  NW  result index n.
- fn  out  W  F(idx).
- exact  out  1  1 when fn == captured v.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=idle, all registers 0, so idx=0, fn=0, exact=0, done_tick=0, ready=1 after the reset edge.
- Reset mid-operation: abandons the search, returns to idle, clears outputs. No done_tick.
- States: idle, op, done. The state type is an enum.
- idle:
  - ready=1.
  - On start: v_reg<=v, t0<=0, t1<=1, n<=1, go to op.
  - Outputs idx/fn/exact keep the previous result.
- op:
  - ready=0. start is ignored.
  - If v_reg==0: n<=0, t1<=0, go to done.
  - Else compute sum=t0+t1 at W+1 bits. The carry must be kept so F(31) overflow at W=20 compares correctly.
  - If sum > v_reg: go to done with the current n, t1.
  - Else: t0<=t1, t1<=sum[W-1:0], n<=n+1, stay in op.
- done:
  - done_tick=1 for exactly one cycle.
  - idx<=n, fn<=t1, exact<=(t1==v_reg), registered on entry so they are valid during done_tick.
  - Next state is idle.
- Tie F(1)=F(2)=1: v=1 must return idx=2 (the largest index).
- Latency: start accepted at edge k; op occupies max(idx,1) cycles; done_tick is high in the cycle after the last op cycle.
  - Total from start edge to done_tick cycle is max(idx,1)+1 cycles.
  - Worst case for W=20 is 31 cycles.
- Back-to-back: start may be asserted in the idle cycle right after done. No dead cycle beyond done.
- The outputs idx/fn/exact are stable from done until the next done. They do not glitch during op.
- Unknown/illegal state encoding goes to idle.

Decomposition:
- Shared package fib_pkg:
  - state_type enum {idle, op, done}, used by both `fib` and fib_index.
  - FIB_W=20 and FIB_NW=5 constants.
  - FIB_MAX_IDX=30 constant.
- No sub-module. The datapath is one W+1-bit adder, one comparator and three registers, so it stays in a single module with the FSMD split into a register always_ff and a next-state always_comb.

Test Plan:
- Reset, then v=0, start pulse -> done_tick exactly 2 cycles after the start edge; idx=0, fn=0, exact=1.
- v=1 -> idx=2, fn=1, exact=1, done_tick 3 cycles after start.
- v=100 -> idx=11, fn=89, exact=0, done_tick 12 cycles after start. Toggling start during op changes nothing.
- v=832040 -> idx=30, fn=832040, exact=1. Then v=1048575 -> idx=30, fn=832040, exact=0 (checks overflow of the W+1-bit sum).
- Start v=500000, assert rst for one cycle during op -> next cycle ready=1, idx=0, fn=0, exact=0, no done_tick. Then v=5 completes with idx=5, fn=5, exact=1.
- Round trip:
  - For i=0..30, drive `fib` with i, feed its f into fib_index, and run back-to-back starts.
  - Require exact=1 and fn=f for all i.
  - Require idx=i for all i except i=1, which must give idx=2.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci FSMD family (fib and fib_index).
package fib_pkg;

  // Value width, index width, and the largest index whose F(n) fits in FIB_W bits.
  localparam int unsigned FIB_W       = 20;
  localparam int unsigned FIB_NW      = 5;
  localparam int unsigned FIB_MAX_IDX = 30;

  // Control states shared by the forward and inverse Fibonacci engines.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_type;

endpackage : fib_pkg

// File: rtl/fib_index.sv
// Inverse Fibonacci: for a captured value v, finds the largest n with F(n) <= v
// and reports n, F(n) and whether F(n) equals v exactly.
module fib_index
  import fib_pkg::*;
#(
  parameter int unsigned W  = FIB_W,
  parameter int unsigned NW = FIB_NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  v,
  output logic          ready,
  output logic          done_tick,
  output logic [NW-1:0] idx,
  output logic [W-1:0]  fn,
  output logic          exact
);

  state_type     state_q, state_d;
  logic [W-1:0]  v_q, v_d;
  logic [W-1:0]  t0_q, t0_d;
  logic [W-1:0]  t1_q, t1_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] idx_q, idx_d;
  logic [W-1:0]  fn_q, fn_d;
  logic          exact_q, exact_d;
  logic [W:0]    sum;

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      fn_q    <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      fn_q    <= fn_d;
      exact_q <= exact_d;
    end
  end

  // Next-state logic: walk the Fibonacci sequence until the next term exceeds v.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    n_d     = n_q;
    idx_d   = idx_q;
    fn_d    = fn_q;
    exact_d = exact_q;
    // Carry bit kept so F(W+11) overflow still compares greater than any v.
    sum     = {1'b0, t0_q} + {1'b0, t1_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          v_d     = v;
          t0_d    = '0;
          t1_d    = W'(1);
          n_d     = NW'(1);
          state_d = OP;
        end
      end
      OP: begin
        if (v_q == '0) begin
          n_d     = '0;
          t1_d    = '0;
          state_d = DONE;
        end else if (sum > {1'b0, v_q}) begin
          state_d = DONE;
        end else begin
          t0_d    = t1_q;
          t1_d    = sum[W-1:0];
          n_d     = n_q + NW'(1);
          state_d = OP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Results are loaded on the edge into DONE so they are valid with done_tick.
    if (state_q == OP && state_d == DONE) begin
      idx_d   = n_d;
      fn_d    = t1_d;
      exact_d = (t1_d == v_q);
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign idx       = idx_q;
  assign fn        = fn_q;
  assign exact     = exact_q;

endmodule : fib_index

// File: tb/tb_fib_index.sv
// Self-checking bench for fib_index: directed table, reset-abort sequence,
// round trip over F(0..30) and random values against a lookup-table model.
module tb_fib_index;
  import fib_pkg::*;

  localparam int W  = FIB_W;
  localparam int NW = FIB_NW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  v;
  logic          ready;
  logic          done_tick;
  logic [NW-1:0] idx;
  logic [W-1:0]  fn;
  logic          exact;

  fib_index #(.W(W), .NW(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .v         (v),
    .ready     (ready),
    .done_tick (done_tick),
    .idx       (idx),
    .fn        (fn),
    .exact     (exact)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  longint unsigned fibs [0:32];

  // Last completed result, used to check the outputs hold steady during op.
  logic [NW-1:0] p_idx;
  logic [W-1:0]  p_fn;
  logic          p_exact;

  typedef struct {
    logic [W-1:0] val;
    int           e_idx;
    logic [W-1:0] e_fn;
    logic         e_exact;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: largest k with F(k) <= val, by scanning the precomputed sequence.
  function automatic int model_idx(input logic [W-1:0] val);
    int n = 0;
    for (int k = 0; k <= 32; k++)
      if (fibs[k] <= longint'(val)) n = k;
    return n;
  endfunction

  // Runs one operation starting in an idle cycle (#1 after an edge); returns in the idle cycle after done.
  task automatic run_op(input logic [W-1:0] val, input int e_idx, input logic [W-1:0] e_fn,
                        input logic e_exact, input bit noisy, input string tag);
    int lat;
    int e_lat;
    bit seen;
    e_lat = ((e_idx > 1) ? e_idx : 1) + 1;
    check({tag, ".ready_idle"}, 64'(ready), 64'd1);
    start = 1'b1;
    v     = val;
    @(posedge clk); #1;
    lat   = 1;
    start = 1'b0;
    v     = W'($urandom);
    seen  = 1'b0;
    while (!seen && lat < 40) begin
      if (done_tick === 1'b1) begin
        seen = 1'b1;
      end else begin
        check({tag, ".hold"}, {ready, idx, fn, exact}, {1'b0, p_idx, p_fn, p_exact});
        if (noisy) begin
          start = 1'($urandom);
          v     = W'($urandom);
        end
        @(posedge clk); #1;
        lat++;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(e_lat));
    check({tag, ".idx"},     64'(idx), 64'(e_idx));
    check({tag, ".fn"},      64'(fn),  64'(e_fn));
    check({tag, ".exact"},   64'(exact), 64'(e_exact));
    p_idx   = NW'(e_idx);
    p_fn    = e_fn;
    p_exact = e_exact;
    @(posedge clk); #1;
    check({tag, ".pulse_idle"}, {done_tick, ready}, {1'b0, 1'b1});
    check({tag, ".stable"}, {idx, fn, exact}, {p_idx, p_fn, p_exact});
  endtask

  initial begin
    fibs[0] = 0;
    fibs[1] = 1;
    for (int k = 2; k <= 32; k++) fibs[k] = fibs[k-1] + fibs[k-2];

    tbl[0] = '{val: 20'd0,       e_idx: 0,  e_fn: 20'd0,      e_exact: 1'b1};
    tbl[1] = '{val: 20'd1,       e_idx: 2,  e_fn: 20'd1,      e_exact: 1'b1};
    tbl[2] = '{val: 20'd100,     e_idx: 11, e_fn: 20'd89,     e_exact: 1'b0};
    tbl[3] = '{val: 20'd832040,  e_idx: 30, e_fn: 20'd832040, e_exact: 1'b1};
    tbl[4] = '{val: 20'd1048575, e_idx: 30, e_fn: 20'd832040, e_exact: 1'b0};
    tbl[5] = '{val: 20'd2,       e_idx: 3,  e_fn: 20'd2,      e_exact: 1'b1};
    tbl[6] = '{val: 20'd4,       e_idx: 4,  e_fn: 20'd3,      e_exact: 1'b0};
    tbl[7] = '{val: 20'd832039,  e_idx: 29, e_fn: 20'd514229, e_exact: 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    v     = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset.outputs", {ready, done_tick, idx, fn, exact}, {1'b1, 1'b0, {NW{1'b0}}, {W{1'b0}}, 1'b0});
    rst     = 1'b0;
    p_idx   = '0;
    p_fn    = '0;
    p_exact = 1'b0;

    // Directed table; the v=100 entry toggles start/v during op.
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].val, tbl[i].e_idx, tbl[i].e_fn, tbl[i].e_exact, (i == 2),
             $sformatf("tbl%0d", i));

    // Reset during op abandons the search with no done_tick.
    start = 1'b1;
    v     = 20'd500000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("abort.in_op", 64'(ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.cleared", {ready, done_tick, idx, fn, exact}, {1'b1, 1'b0, {NW{1'b0}}, {W{1'b0}}, 1'b0});
    begin
      int pulses = 0;
      repeat (35) begin
        @(posedge clk); #1;
        if (done_tick === 1'b1) pulses++;
      end
      check("abort.no_done", 64'(pulses), 64'd0);
    end
    p_idx   = '0;
    p_fn    = '0;
    p_exact = 1'b0;
    run_op(20'd5, 5, 20'd5, 1'b1, 1'b0, "after_abort");

    // Round trip over every representable Fibonacci number, back to back.
    for (int i = 0; i <= FIB_MAX_IDX; i++)
      run_op(W'(fibs[i]), (i == 1) ? 2 : i, W'(fibs[i]), 1'b1, 1'b0, $sformatf("rt%0d", i));

    // Random values, half of them placed right around a Fibonacci number.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] val;
      int n;
      if (i % 2 == 0) begin
        val = W'($urandom_range(0, (1 << W) - 1));
      end else begin
        int k = $urandom_range(2, 30);
        int d = $urandom_range(0, 2);
        val = W'(fibs[k] + longint'(d) - 1);
      end
      n = model_idx(val);
      run_op(val, n, W'(fibs[n]), (fibs[n] == longint'(val)), (i % 3 == 0),
             $sformatf("rnd%0d_v%0d", i, val));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fib_index
